cci_mpf_shim_vtp_miss_arb: RTL and testbench

Miss scheduler for the VTP translation path. It collects TLB miss notifications from both lookup ports, holds them in a small table of outstanding misses, and drops duplicates. It issues one page-table walk per unique miss and sequences the walk result into the TLB fill port. It sits between the TLB's miss/fill signals and the page table walker, making the walker and the single fill port shared resources for both lookup ports.

---
 rtl/cci_mpf_shim_vtp_miss_arb_pkg.sv | 28 ++
 rtl/cci_mpf_shim_vtp_miss_arb_if.sv | 52 +++++
 rtl/cci_mpf_shim_vtp_miss_tag_fifo.sv | 55 +++++
 rtl/cci_mpf_shim_vtp_miss_arb.sv | 197 +++++++++++++++++++
 tb/tb_cci_mpf_shim_vtp_miss_arb.sv | 315 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/cci_mpf_shim_vtp_miss_arb_pkg.sv
// ============================================================================
// Module : cci_mpf_shim_vtp_miss_arb_pkg
// Brief  : Shared VTP miss-scheduler types: entry state, tag and page indices.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package cci_mpf_shim_vtp_miss_arb_pkg;

    localparam int c_VTP_N_MISS_ENTRIES = 4;
    localparam int c_VTP_VA_IDX_BITS    = 36;
    localparam int c_VTP_PA_IDX_BITS    = 26;
    localparam int c_VTP_MISS_TAG_BITS  = $clog2(c_VTP_N_MISS_ENTRIES);

    typedef enum logic [1:0] {
        FREE    = 2'd0,
        PENDING = 2'd1,
        WALKING = 2'd2,
        FILLING = 2'd3
    } t_vtp_miss_state;

    typedef logic [c_VTP_MISS_TAG_BITS-1:0] t_vtp_miss_tag;
    typedef logic [c_VTP_VA_IDX_BITS-1:0]   t_tlb_4k_va_page_idx;
    typedef logic [c_VTP_PA_IDX_BITS-1:0]   t_tlb_4k_pa_page_idx;

endpackage

`default_nettype wire

// File: rtl/cci_mpf_shim_vtp_miss_arb_if.sv
// ============================================================================
// Module : cci_mpf_shim_vtp_miss_arb_if
// Brief  : TLB miss / walker / TLB fill signal bundle for the miss scheduler.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

interface cci_mpf_shim_vtp_miss_arb_if #(
    parameter int N_MISS_ENTRIES = cci_mpf_shim_vtp_miss_arb_pkg::c_VTP_N_MISS_ENTRIES,
    parameter int VA_IDX_BITS    = cci_mpf_shim_vtp_miss_arb_pkg::c_VTP_VA_IDX_BITS,
    parameter int PA_IDX_BITS    = cci_mpf_shim_vtp_miss_arb_pkg::c_VTP_PA_IDX_BITS
);
    localparam int TAG_BITS = $clog2(N_MISS_ENTRIES);

    logic [1:0]                  miss_en;
    logic [1:0][VA_IDX_BITS-1:0] miss_va;
    logic [1:0]                  miss_rdy;

    logic                   walk_req_en;
    logic [VA_IDX_BITS-1:0] walk_req_va;
    logic [TAG_BITS-1:0]    walk_req_tag;
    logic                   walk_req_rdy;

    logic                   walk_rsp_en;
    logic [TAG_BITS-1:0]    walk_rsp_tag;
    logic [PA_IDX_BITS-1:0] walk_rsp_pa;
    logic                   walk_rsp_big;

    logic                   fill_en;
    logic [VA_IDX_BITS-1:0] fill_va;
    logic [PA_IDX_BITS-1:0] fill_pa;
    logic                   fill_big;
    logic                   fill_rdy;

    logic [TAG_BITS:0]      n_outstanding;

    modport master (
        input  miss_en, miss_va, walk_req_rdy,
               walk_rsp_en, walk_rsp_tag, walk_rsp_pa, walk_rsp_big, fill_rdy,
        output miss_rdy, walk_req_en, walk_req_va, walk_req_tag,
               fill_en, fill_va, fill_pa, fill_big, n_outstanding
    );

    modport slave (
        output miss_en, miss_va, walk_req_rdy,
               walk_rsp_en, walk_rsp_tag, walk_rsp_pa, walk_rsp_big, fill_rdy,
        input  miss_rdy, walk_req_en, walk_req_va, walk_req_tag,
               fill_en, fill_va, fill_pa, fill_big, n_outstanding
    );
endinterface

`default_nettype wire

// File: rtl/cci_mpf_shim_vtp_miss_tag_fifo.sv
// ============================================================================
// Module : cci_mpf_shim_vtp_miss_tag_fifo
// Brief  : Allocation-order tag FIFO; tags are unique so it never overflows.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module cci_mpf_shim_vtp_miss_tag_fifo #(
    parameter int N_ENTRIES = cci_mpf_shim_vtp_miss_arb_pkg::c_VTP_N_MISS_ENTRIES
)(
    input  wire                         clk,
    input  wire                         reset,
    input  wire                         i_enqEn,
    input  wire [$clog2(N_ENTRIES)-1:0] i_enqTag,
    input  wire                         i_deqEn,
    output logic                        o_notEmpty,
    output logic [$clog2(N_ENTRIES)-1:0] o_first
);
    localparam int TAG_BITS = $clog2(N_ENTRIES);

    logic [TAG_BITS-1:0] r_mem [N_ENTRIES];
    logic [TAG_BITS-1:0] r_wrPtr;
    logic [TAG_BITS-1:0] r_rdPtr;
    logic [TAG_BITS:0]   r_count;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            r_count <= '0;
            for (int i = 0; i < N_ENTRIES; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            if (i_enqEn) begin
                r_mem[r_wrPtr] <= i_enqTag;
                r_wrPtr        <= r_wrPtr + TAG_BITS'(1);
            end
            if (i_deqEn) begin
                r_rdPtr <= r_rdPtr + TAG_BITS'(1);
            end
            case ({i_enqEn, i_deqEn})
                2'b10:   r_count <= r_count + (TAG_BITS+1)'(1);
                2'b01:   r_count <= r_count - (TAG_BITS+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_notEmpty = (r_count != '0);
    assign o_first    = r_mem[r_rdPtr];

endmodule

`default_nettype wire

// File: rtl/cci_mpf_shim_vtp_miss_arb.sv
// ============================================================================
// Module : cci_mpf_shim_vtp_miss_arb
// Brief  : VTP miss scheduler: tracks outstanding TLB misses, issues one walk
//          per entry and serialises walk results onto the TLB fill port.
//          CCI_MPF_VTP_MISS_DEDUP_EN merges misses to VAs already in flight.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module cci_mpf_shim_vtp_miss_arb
    import cci_mpf_shim_vtp_miss_arb_pkg::*;
#(
    parameter int N_MISS_ENTRIES = c_VTP_N_MISS_ENTRIES,
    parameter int VA_IDX_BITS    = c_VTP_VA_IDX_BITS,
    parameter int PA_IDX_BITS    = c_VTP_PA_IDX_BITS
)(
    input  wire clk,
    input  wire reset,
    cci_mpf_shim_vtp_miss_arb_if.master ifc
);
    localparam int TAG_BITS = $clog2(N_MISS_ENTRIES);

    t_vtp_miss_state        r_state [N_MISS_ENTRIES];
    logic [VA_IDX_BITS-1:0] r_va    [N_MISS_ENTRIES];
    logic [PA_IDX_BITS-1:0] r_pa    [N_MISS_ENTRIES];
    logic [N_MISS_ENTRIES-1:0] r_big;
    logic                   r_rrPtr;
    logic [TAG_BITS:0]      r_nOutstanding;
    logic                   r_fillLocked;
    logic [TAG_BITS-1:0]    r_fillLockTag;

    logic                   w_anyFree;
    logic [TAG_BITS-1:0]    w_freeIdx;
    logic                   w_anyFilling;
    logic [TAG_BITS-1:0]    w_fillingIdx;
    logic [1:0]             w_dup;
    logic                   w_sameVa;
    logic [1:0]             w_cand;
    logic                   w_winner;
    logic                   w_merge;
    logic                   w_alloc;
    logic [VA_IDX_BITS-1:0] w_allocVa;
    logic [1:0]             w_missRdy;
    logic                   w_walkPending;
    logic [TAG_BITS-1:0]    w_walkTag;
    logic                   w_walkHs;
    logic                   w_rspOk;
    logic [TAG_BITS-1:0]    w_fillTag;
    logic                   w_fillHs;

    // Lowest-index FREE and FILLING entries
    always_comb begin
        w_anyFree    = 1'b0;
        w_freeIdx    = '0;
        w_anyFilling = 1'b0;
        w_fillingIdx = '0;
        for (int i = N_MISS_ENTRIES - 1; i >= 0; i--) begin
            if (r_state[i] == FREE) begin
                w_anyFree = 1'b1;
                w_freeIdx = TAG_BITS'(i);
            end
            if (r_state[i] == FILLING) begin
                w_anyFilling = 1'b1;
                w_fillingIdx = TAG_BITS'(i);
            end
        end
    end

`ifdef CCI_MPF_VTP_MISS_DEDUP_EN
    always_comb begin
        w_dup = '0;
        for (int p = 0; p < 2; p++) begin
            for (int i = 0; i < N_MISS_ENTRIES; i++) begin
                if (ifc.miss_en[p] && (r_state[i] != FREE) && (r_va[i] == ifc.miss_va[p])) begin
                    w_dup[p] = 1'b1;
                end
            end
        end
    end
    assign w_sameVa = (ifc.miss_va[0] == ifc.miss_va[1]);
`else
    assign w_dup    = 2'b00;
    assign w_sameVa = 1'b0;
`endif

    // Ports already covered by an in-flight entry don't compete for allocation
    assign w_cand    = ifc.miss_en & ~w_dup;
    assign w_winner  = (w_cand == 2'b11) ? r_rrPtr : w_cand[1];
    assign w_merge   = (w_cand == 2'b11) && w_sameVa;
    assign w_alloc   = w_anyFree && (w_cand != 2'b00);
    assign w_allocVa = ifc.miss_va[w_winner];

    assign w_missRdy[0] = w_dup[0] | (w_anyFree & ((w_winner == 1'b0) | !w_cand[1] | w_merge));
    assign w_missRdy[1] = w_dup[1] | (w_anyFree & ((w_winner == 1'b1) | !w_cand[0] | w_merge));
    assign ifc.miss_rdy = w_missRdy;

    cci_mpf_shim_vtp_miss_tag_fifo #(
        .N_ENTRIES (N_MISS_ENTRIES)
    ) u_tagFifo (
        .clk        (clk),
        .reset      (reset),
        .i_enqEn    (w_alloc),
        .i_enqTag   (w_freeIdx),
        .i_deqEn    (w_walkHs),
        .o_notEmpty (w_walkPending),
        .o_first    (w_walkTag)
    );

    assign w_walkHs         = w_walkPending & ifc.walk_req_rdy;
    assign ifc.walk_req_en  = w_walkPending;
    assign ifc.walk_req_tag = w_walkPending ? w_walkTag : '0;
    assign ifc.walk_req_va  = w_walkPending ? r_va[w_walkTag] : '0;

    assign w_rspOk = ifc.walk_rsp_en && (r_state[ifc.walk_rsp_tag] == WALKING);

    // Once presented, a fill stays on the port until accepted
    assign w_fillTag    = r_fillLocked ? r_fillLockTag : w_fillingIdx;
    assign w_fillHs     = w_anyFilling & ifc.fill_rdy;
    assign ifc.fill_en  = w_anyFilling;
    assign ifc.fill_va  = w_anyFilling ? r_va[w_fillTag] : '0;
    assign ifc.fill_pa  = w_anyFilling ? r_pa[w_fillTag] : '0;
    assign ifc.fill_big = w_anyFilling & r_big[w_fillTag];

    assign ifc.n_outstanding = r_nOutstanding;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rrPtr        <= 1'b0;
            r_nOutstanding <= '0;
            r_fillLocked   <= 1'b0;
            r_fillLockTag  <= '0;
            r_big          <= '0;
            for (int i = 0; i < N_MISS_ENTRIES; i++) begin
                r_state[i] <= FREE;
                r_va[i]    <= '0;
                r_pa[i]    <= '0;
            end
        end else begin
            if ((ifc.miss_en == 2'b11) && w_alloc) begin
                r_rrPtr <= ~r_rrPtr;
            end

            case ({w_alloc, w_fillHs})
                2'b10:   r_nOutstanding <= r_nOutstanding + (TAG_BITS+1)'(1);
                2'b01:   r_nOutstanding <= r_nOutstanding - (TAG_BITS+1)'(1);
                default: r_nOutstanding <= r_nOutstanding;
            endcase

            if (w_fillHs) begin
                r_fillLocked <= 1'b0;
            end else if (w_anyFilling) begin
                r_fillLocked  <= 1'b1;
                r_fillLockTag <= w_fillTag;
            end

            for (int i = 0; i < N_MISS_ENTRIES; i++) begin
                case (r_state[i])
                    FREE: begin
                        if (w_alloc && (w_freeIdx == TAG_BITS'(i))) begin
                            r_state[i] <= PENDING;
                            r_va[i]    <= w_allocVa;
                        end
                    end
                    PENDING: begin
                        if (w_walkHs && (w_walkTag == TAG_BITS'(i))) begin
                            r_state[i] <= WALKING;
                        end
                    end
                    WALKING: begin
                        if (w_rspOk && (ifc.walk_rsp_tag == TAG_BITS'(i))) begin
                            r_state[i] <= FILLING;
                            r_pa[i]    <= ifc.walk_rsp_pa;
                            r_big[i]   <= ifc.walk_rsp_big;
                        end
                    end
                    FILLING: begin
                        if (w_fillHs && (w_fillTag == TAG_BITS'(i))) begin
                            r_state[i] <= FREE;
                        end
                    end
                    default: r_state[i] <= FREE;
                endcase
            end
        end
    end

    // Stray responses are dropped; flag them in simulation
    always @(posedge clk) begin
        if (!reset && ifc.walk_rsp_en) begin
            assert (r_state[ifc.walk_rsp_tag] == WALKING)
                else $warning("walk response for non-walking tag %0d dropped", ifc.walk_rsp_tag);
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_cci_mpf_shim_vtp_miss_arb.sv
// ============================================================================
// Module : tb_cci_mpf_shim_vtp_miss_arb
// Brief  : Directed self-checking bench for the VTP miss scheduler.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_cci_mpf_shim_vtp_miss_arb;

    logic clk = 1'b0;
    logic reset;
    int   errors = 0;
    int   checks = 0;
    int   nWalk  = 0;
    int   nFill  = 0;
    bit   cntEn  = 1'b0;
    int   expDup;

    always #5 clk = ~clk;

    cci_mpf_shim_vtp_miss_arb_if #(
        .N_MISS_ENTRIES (4),
        .VA_IDX_BITS    (36),
        .PA_IDX_BITS    (26)
    ) vif ();

    cci_mpf_shim_vtp_miss_arb #(
        .N_MISS_ENTRIES (4),
        .VA_IDX_BITS    (36),
        .PA_IDX_BITS    (26)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .ifc   (vif)
    );

    always @(negedge clk) begin
        if (cntEn) begin
            if (vif.walk_req_en && vif.walk_req_rdy) nWalk++;
            if (vif.fill_en && vif.fill_rdy)         nFill++;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic doReset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        tick();
    endtask

    initial begin
        int rspOrder [4];
        int fillOrder [4];
        rspOrder  = '{3, 1, 0, 2};
        fillOrder = '{3, 0, 1, 2};

        reset            = 1'b1;
        vif.miss_en      = 2'b00;
        vif.miss_va      = '0;
        vif.walk_req_rdy = 1'b0;
        vif.walk_rsp_en  = 1'b0;
        vif.walk_rsp_tag = '0;
        vif.walk_rsp_pa  = '0;
        vif.walk_rsp_big = 1'b0;
        vif.fill_rdy     = 1'b0;
        tick();
        tick();

        // Reset values
        chk("rst_miss_rdy", vif.miss_rdy, 2'b11);
        chk("rst_walk_en", vif.walk_req_en, 1'b0);
        chk("rst_walk_va", vif.walk_req_va, 36'h0);
        chk("rst_fill_en", vif.fill_en, 1'b0);
        chk("rst_fill_va", vif.fill_va, 36'h0);
        chk("rst_nout", vif.n_outstanding, 3'd0);
        reset = 1'b0;
        tick();

        // Single miss end to end
        vif.miss_en = 2'b01;
        vif.miss_va[0] = 36'h123;
        #1 chk("single_rdy", vif.miss_rdy, 2'b01);
        tick();
        vif.miss_en = 2'b00;
        chk("single_walk_en", vif.walk_req_en, 1'b1);
        chk("single_walk_tag", vif.walk_req_tag, 2'd0);
        chk("single_walk_va", vif.walk_req_va, 36'h123);
        chk("single_nout1", vif.n_outstanding, 3'd1);
        vif.walk_req_rdy = 1'b1;
        tick();
        vif.walk_req_rdy = 1'b0;
        chk("single_walk_done", vif.walk_req_en, 1'b0);
        tick();
        vif.walk_rsp_en = 1'b1; vif.walk_rsp_tag = 2'd0; vif.walk_rsp_pa = 26'h45; vif.walk_rsp_big = 1'b0;
        tick();
        vif.walk_rsp_en = 1'b0;
        chk("single_fill_en", vif.fill_en, 1'b1);
        chk("single_fill_va", vif.fill_va, 36'h123);
        chk("single_fill_pa", vif.fill_pa, 26'h45);
        chk("single_fill_big", vif.fill_big, 1'b0);
        vif.fill_rdy = 1'b1;
        tick();
        vif.fill_rdy = 1'b0;
        chk("single_fill_done", vif.fill_en, 1'b0);
        chk("single_nout0", vif.n_outstanding, 3'd0);

        // Both ports every cycle: alternating grants, table fills, full stall
        vif.walk_req_rdy = 1'b1;
        vif.miss_en = 2'b11; vif.miss_va[0] = 36'h10; vif.miss_va[1] = 36'h11;
        #1 chk("rr_a_rdy", vif.miss_rdy, 2'b01);
        tick();
        vif.miss_va[0] = 36'h12;
        #1 chk("rr_b_rdy", vif.miss_rdy, 2'b10);
        chk("rr_b_walk_tag", vif.walk_req_tag, 2'd0);
        chk("rr_b_walk_va", vif.walk_req_va, 36'h10);
        tick();
        vif.miss_va[1] = 36'h13;
        #1 chk("rr_c_rdy", vif.miss_rdy, 2'b01);
        chk("rr_c_walk_tag", vif.walk_req_tag, 2'd1);
        chk("rr_c_walk_va", vif.walk_req_va, 36'h11);
        tick();
        vif.miss_va[0] = 36'h14;
        #1 chk("rr_d_rdy", vif.miss_rdy, 2'b10);
        tick();
        vif.miss_va[1] = 36'h15;
        #1 chk("full_rdy", vif.miss_rdy, 2'b00);
        chk("full_nout", vif.n_outstanding, 3'd4);
        chk("full_walk_tag", vif.walk_req_tag, 2'd3);
        chk("full_walk_va", vif.walk_req_va, 36'h13);
        tick();
        vif.walk_req_rdy = 1'b0;
        vif.walk_rsp_en = 1'b1; vif.walk_rsp_tag = 2'd0; vif.walk_rsp_pa = 26'h50;
        #1 chk("full_rdy_rsp", vif.miss_rdy, 2'b00);
        tick();
        vif.walk_rsp_en = 1'b0;
        vif.fill_rdy = 1'b1;
        #1 chk("full_fill_va", vif.fill_va, 36'h10);
        chk("full_fill_pa", vif.fill_pa, 26'h50);
        chk("full_rdy_fillcyc", vif.miss_rdy, 2'b00);
        tick();
        vif.fill_rdy = 1'b0;
        #1 chk("freed_rdy", vif.miss_rdy, 2'b01);
        chk("freed_nout", vif.n_outstanding, 3'd3);
        chk("freed_fill_en", vif.fill_en, 1'b0);
        vif.miss_en = 2'b00;
        doReset();

        // Out-of-order walk responses
        vif.walk_req_rdy = 1'b1;
        for (int k = 0; k < 4; k++) begin
            vif.miss_en = 2'b01;
            vif.miss_va[0] = 36'(36'h300 + k);
            tick();
        end
        vif.miss_en = 2'b00;
        tick();
        vif.walk_req_rdy = 1'b0;
        #1 chk("ooo_walks_done", vif.walk_req_en, 1'b0);
        chk("ooo_nout", vif.n_outstanding, 3'd4);
        for (int k = 0; k < 4; k++) begin
            vif.walk_rsp_en  = 1'b1;
            vif.walk_rsp_tag = 2'(rspOrder[k]);
            vif.walk_rsp_pa  = 26'(26'h70 + rspOrder[k]);
            tick();
        end
        vif.walk_rsp_en = 1'b0;
        vif.fill_rdy = 1'b1;
        for (int j = 0; j < 4; j++) begin
            #1 chk("ooo_fill_va", vif.fill_va, 64'(36'h300 + fillOrder[j]));
            chk("ooo_fill_pa", vif.fill_pa, 64'(26'h70 + fillOrder[j]));
            tick();
        end
        vif.fill_rdy = 1'b0;
        #1 chk("ooo_fill_idle", vif.fill_en, 1'b0);
        chk("ooo_nout0", vif.n_outstanding, 3'd0);

        // Duplicate VAs
        vif.walk_req_rdy = 1'b1;
        vif.fill_rdy = 1'b1;
        nWalk = 0;
        nFill = 0;
        cntEn = 1'b1;
        vif.miss_en = 2'b11; vif.miss_va[0] = 36'h200; vif.miss_va[1] = 36'h200;
`ifdef CCI_MPF_VTP_MISS_DEDUP_EN
        expDup = 1;
        #1 chk("dup_c1_rdy", vif.miss_rdy, 2'b11);
        tick();
        vif.miss_en = 2'b01;
        #1 chk("dup_c2_rdy", vif.miss_rdy, 2'b11);
        tick();
`else
        expDup = 3;
        #1 chk("dup_c1_rdy", vif.miss_rdy, 2'b01);
        tick();
        #1 chk("dup_c2_rdy", vif.miss_rdy, 2'b10);
        tick();
        vif.miss_en = 2'b01;
        #1 chk("dup_c3_rdy", vif.miss_rdy, 2'b01);
        tick();
`endif
        vif.miss_en = 2'b00;
        tick(); tick(); tick();
        vif.walk_req_rdy = 1'b0;
        for (int t = 0; t < expDup; t++) begin
            vif.walk_rsp_en  = 1'b1;
            vif.walk_rsp_tag = 2'(t);
            vif.walk_rsp_pa  = 26'h88;
            tick();
        end
        vif.walk_rsp_en = 1'b0;
        tick(); tick(); tick();
        cntEn = 1'b0;
        vif.fill_rdy = 1'b0;
        chk("dup_walks", 64'(nWalk), 64'(expDup));
        chk("dup_fills", 64'(nFill), 64'(expDup));
        chk("dup_nout0", vif.n_outstanding, 3'd0);

        // Backpressure on walker and fill port
        vif.miss_en = 2'b01; vif.miss_va[0] = 36'h5A5;
        tick();
        vif.miss_va[0] = 36'h5A6;
        tick();
        vif.miss_en = 2'b00;
        #1 chk("bp_nout2", vif.n_outstanding, 3'd2);
        for (int k = 0; k < 10; k++) begin
            chk("bp_walk_en", vif.walk_req_en, 1'b1);
            chk("bp_walk_va", vif.walk_req_va, 36'h5A5);
            tick();
        end
        vif.walk_req_rdy = 1'b1;
        #1 chk("bp_walk_tag0", vif.walk_req_tag, 2'd0);
        tick();
        chk("bp_walk_tag1", vif.walk_req_tag, 2'd1);
        chk("bp_walk_va1", vif.walk_req_va, 36'h5A6);
        tick();
        vif.walk_req_rdy = 1'b0;
        #1 chk("bp_walk_idle", vif.walk_req_en, 1'b0);
        tick();
        vif.walk_rsp_en = 1'b1; vif.walk_rsp_tag = 2'd0; vif.walk_rsp_pa = 26'h3C; vif.walk_rsp_big = 1'b1;
        tick();
        vif.walk_rsp_tag = 2'd1; vif.walk_rsp_pa = 26'h3D; vif.walk_rsp_big = 1'b0;
        tick();
        vif.walk_rsp_en = 1'b0;
        for (int k = 0; k < 5; k++) begin
            #1 chk("bp_fill_va", vif.fill_va, 36'h5A5);
            chk("bp_fill_pa", vif.fill_pa, 26'h3C);
            chk("bp_fill_big", vif.fill_big, 1'b1);
            tick();
        end
        vif.fill_rdy = 1'b1;
        #1 chk("bp_fill_first", vif.fill_va, 36'h5A5);
        tick();
        chk("bp_fill_va1", vif.fill_va, 36'h5A6);
        chk("bp_fill_pa1", vif.fill_pa, 26'h3D);
        chk("bp_fill_big1", vif.fill_big, 1'b0);
        tick();
        vif.fill_rdy = 1'b0;
        #1 chk("bp_fill_idle", vif.fill_en, 1'b0);
        chk("bp_nout0", vif.n_outstanding, 3'd0);

        // Reset with two walks in flight; a late response must be dropped
        vif.miss_en = 2'b01; vif.miss_va[0] = 36'h610;
        tick();
        vif.miss_va[0] = 36'h611;
        vif.walk_req_rdy = 1'b1;
        tick();
        vif.miss_en = 2'b00;
        tick();
        vif.walk_req_rdy = 1'b0;
        #1 chk("mid_nout2", vif.n_outstanding, 3'd2);
        chk("mid_walk_idle", vif.walk_req_en, 1'b0);
        reset = 1'b1;
        #1 chk("mid_rst_nout", vif.n_outstanding, 3'd0);
        chk("mid_rst_rdy", vif.miss_rdy, 2'b11);
        chk("mid_rst_walk_en", vif.walk_req_en, 1'b0);
        chk("mid_rst_fill_en", vif.fill_en, 1'b0);
        tick();
        reset = 1'b0;
        tick();
        vif.walk_rsp_en = 1'b1; vif.walk_rsp_tag = 2'd1; vif.walk_rsp_pa = 26'h99; vif.walk_rsp_big = 1'b0;
        tick();
        vif.walk_rsp_en = 1'b0;
        #1 chk("late_fill_en", vif.fill_en, 1'b0);
        chk("late_fill_va", vif.fill_va, 36'h0);
        chk("late_nout", vif.n_outstanding, 3'd0);
        tick();
        chk("late_fill_en2", vif.fill_en, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
